// File: rtl/lstm_cell_update.sv
// LSTM cell-state update stage: c(t) = f*c(t-1) + i*g, read from / written back to memory_cell.
// Optional macro CELL_SAT_EN: saturate the new cell state instead of two's-complement wrap.
module lstm_cell_update #(
  parameter int ADDR     = 12,
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int NUM      = 53,
  parameter int TIMESTEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] f_gate,
  input  logic [WIDTH-1:0] i_gate,
  input  logic [WIDTH-1:0] g_cand,
  output logic [ADDR-1:0]  rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             wr_en,
  output logic [ADDR-1:0]  wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             c_valid,
  output logic [WIDTH-1:0] c_out,
  output logic [ADDR-1:0]  t_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR-1:0] NUM_A  = ADDR'(NUM);
  localparam logic [ADDR-1:0] LAST_T = ADDR'(TIMESTEP - 1);

  // The saturating build keeps the exact sum; the wrapping build only needs the low bits.
`ifdef CELL_SAT_EN
  localparam int SW = 2 * WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  function automatic logic [WIDTH-1:0] cell_clip(input logic [SW-1:0] s);
`ifdef CELL_SAT_EN
    if ((&s[SW-1:WIDTH-1]) | ~(|s[SW-1:WIDTH-1])) begin
      return s[WIDTH-1:0];
    end else if (s[SW-1]) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    return s;
`endif
  endfunction

  state_t                   r_state, w_state_nxt;
  logic [ADDR-1:0]          r_k, w_k_nxt, r_t, r_rd_addr, w_rd_base;
  logic                     r_in_ready, w_accept;
  logic [WIDTH-1:0]         r_f, r_i, r_g;
  logic                     r_v1;
  logic [ADDR-1:0]          r_k1;
  logic                     r_wr_en;
  logic [ADDR-1:0]          r_wr_addr;
  logic [WIDTH-1:0]         r_wr_data;
  logic                     r_busy, r_done;
  logic [WIDTH-1:0]         w_prev;
  logic signed [2*WIDTH-1:0] w_f_x, w_prev_x, w_i_x, w_g_x;
  logic [SW-1:0]            w_p1, w_p2, w_sum;

  assign w_accept = in_valid & r_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_k_nxt     = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_k_nxt = r_k + ADDR'(1);
          if (r_k == NUM_A - ADDR'(1)) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_k_nxt = r_k;
        end
      end
      S_DRAIN: begin
        if (!r_v1) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Timestep 0 has no predecessor, so its reads are issued from address 0 and ignored.
  always_comb begin
    if (r_t == '0) begin
      w_rd_base = '0;
    end else begin
      w_rd_base = (r_t - ADDR'(1)) * NUM_A;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_t        <= '0;
      r_rd_addr  <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_in_ready <= (w_state_nxt == S_RUN);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      if (r_state == S_IDLE && start) begin
        r_rd_addr <= w_rd_base;
      end else if (w_accept) begin
        r_rd_addr <= r_rd_addr + ADDR'(1);
      end
      if (r_state == S_DONE) begin
        r_t <= (r_t == LAST_T) ? '0 : r_t + ADDR'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_k1 <= '0;
      r_f  <= '0;
      r_i  <= '0;
      r_g  <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_k1 <= r_k;
        r_f  <= f_gate;
        r_i  <= i_gate;
        r_g  <= g_cand;
      end
    end
  end

  always_comb begin
    if (r_t != '0) begin
      w_prev = rd_data;
    end else begin
      w_prev = '0;
    end
  end

  assign w_f_x    = {{WIDTH{r_f[WIDTH-1]}}, r_f};
  assign w_prev_x = {{WIDTH{w_prev[WIDTH-1]}}, w_prev};
  assign w_i_x    = {{WIDTH{r_i[WIDTH-1]}}, r_i};
  assign w_g_x    = {{WIDTH{r_g[WIDTH-1]}}, r_g};
  assign w_p1     = SW'((w_f_x * w_prev_x) >>> FRAC);
  assign w_p2     = SW'((w_i_x * w_g_x) >>> FRAC);
  assign w_sum    = w_p1 + w_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= r_v1;
      if (r_v1) begin
        r_wr_addr <= r_t * NUM_A + r_k1;
        r_wr_data <= cell_clip(w_sum);
      end
    end
  end

  assign in_ready = r_in_ready;
  assign rd_addr  = r_rd_addr;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign c_valid  = r_wr_en;
  assign c_out    = r_wr_data;
  assign t_idx    = r_t;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
